wb_event_buffer: RTL and testbench

Write-event buffer downstream of the `mips` pipeline core. Captures register-file writes (WB stage) and data-memory writes (MEM stage), drops writes to `$0`, and queues the rest in program order in a dual-push, single-pop FIFO. A trace printer or checker drains the FIFO over a valid/ready port. Overflow never stalls the core: excess events are dropped, counted, and flagged.

---
 rtl/wb_event_pkg.sv | 17 +
 rtl/evt_fifo_2w1r.sv | 53 +++++
 rtl/wb_event_buffer.sv | 117 +++++++++++
 tb/tb_wb_event_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_event_pkg.sv
// Shared types for the write-event buffer: event kind codes, the 97-bit event record
// and the drop counter width.
package wb_event_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    localparam int unsigned DROP_W = 16;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } wb_event_t;

endpackage

// File: rtl/evt_fifo_2w1r.sv
// Event FIFO with two ordered push ports (port 0 lands first) and one pop port.
// The caller guarantees pushes never exceed free space and pops never hit an empty FIFO.
module evt_fifo_2w1r
    import wb_event_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push0,
    input  wb_event_t               i_data0,
    input  logic                    i_push1,
    input  wb_event_t               i_data1,
    input  logic                    i_pop,
    output wb_event_t               o_head,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    wb_event_t     r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_wptr1;

    // Port 1 lands behind port 0 when both push, otherwise it takes the current slot.
    assign w_wptr1 = r_wptr + AW'(i_push0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(i_push0) + AW'(i_push1);
            r_rptr  <= r_rptr + AW'(i_pop);
            r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (i_push0) r_mem[r_wptr]  <= i_data0;
            if (i_push1) r_mem[w_wptr1] <= i_data1;
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/wb_event_buffer.sv
// Captures GRF and DM write events from the core, filters $0 writes, arbitrates FIFO space
// (GRF before DM) and accounts for dropped events without ever stalling the core.
module wb_event_buffer
    import wb_event_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        grf_we,
    input  logic [31:0] grf_pc,
    input  logic [4:0]  grf_addr,
    input  logic [31:0] grf_wdata,
    input  logic        dm_we,
    input  logic [31:0] dm_pc,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_kind,
    output logic [31:0] out_pc,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = DROP_W + 1;

    logic              w_grf_qual;
    logic              w_dm_qual;
    logic [1:0]        w_n_qual;
    logic [1:0]        w_n_push;
    logic [1:0]        w_n_drop;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_free;
    logic              w_push0;
    logic              w_push1;
    logic              w_pop;
    wb_event_t         w_grf_evt;
    wb_event_t         w_dm_evt;
    wb_event_t         w_push0_data;
    wb_event_t         w_head;
    logic [SUM_W-1:0]  w_drop_sum;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;

    assign w_grf_qual = grf_we && (grf_addr != 5'd0);
    assign w_dm_qual  = dm_we;

    assign w_grf_evt = '{kind: KIND_GRF, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_wdata};
    assign w_dm_evt  = '{kind: KIND_DM, pc: dm_pc, addr: dm_addr, data: dm_wdata};

    // Free space uses the start-of-cycle count; a same-cycle pop does not help.
    assign w_free = CW'(DEPTH) - w_count;

    always_comb begin
        w_n_qual = 2'(w_grf_qual) + 2'(w_dm_qual);
        w_n_push = w_n_qual;
        if (w_free < CW'(w_n_qual)) begin
            w_n_push = w_free[1:0];
        end
        w_n_drop = w_n_qual - w_n_push;
    end

    // Port 0 carries the older event; port 1 is only ever the DM half of a dual push.
    assign w_push0      = (w_n_push != 2'd0);
    assign w_push1      = (w_n_push == 2'd2);
    assign w_push0_data = w_grf_qual ? w_grf_evt : w_dm_evt;

    assign out_valid = (w_count != '0);
    assign w_pop     = out_valid && out_ready;

    evt_fifo_2w1r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push0 (w_push0),
        .i_data0 (w_push0_data),
        .i_push1 (w_push1),
        .i_data1 (w_dm_evt),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign w_drop_sum = {1'b0, r_drop_count} + SUM_W'(w_n_drop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_n_drop != 2'd0) begin
            r_overflow   <= 1'b1;
            r_drop_count <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
        end
    end

    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    always_comb begin
        out_kind = 1'b0;
        out_pc   = '0;
        out_addr = '0;
        out_data = '0;
        if (out_valid) begin
            out_kind = w_head.kind;
            out_pc   = w_head.pc;
            out_addr = w_head.addr;
            out_data = w_head.data;
        end
    end

endmodule

// File: tb/tb_wb_event_buffer.sv
// Directed bench for wb_event_buffer: reset, filtering, ordering, overflow, flush and
// drop counter saturation, sampled on the falling clock edge.
module tb_wb_event_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        grf_we;
    logic [31:0] grf_pc;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wdata;
    logic        dm_we;
    logic [31:0] dm_pc;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        overflow;
    logic [15:0] drop_count;

    int n_total = 0;
    int n_pass  = 0;

    logic [97:0] obs;
    assign obs = {out_valid, out_kind, out_pc, out_addr, out_data};

    always #5 clk = ~clk;

    wb_event_buffer #(
        .DEPTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .grf_we     (grf_we),
        .grf_pc     (grf_pc),
        .grf_addr   (grf_addr),
        .grf_wdata  (grf_wdata),
        .dm_we      (dm_we),
        .dm_pc      (dm_pc),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kind   (out_kind),
        .out_pc     (out_pc),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_ev();
        grf_we = 0; grf_pc = 0; grf_addr = 0; grf_wdata = 0;
        dm_we = 0; dm_pc = 0; dm_addr = 0; dm_wdata = 0;
    endtask

    task automatic set_grf(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        grf_we = 1; grf_addr = a; grf_wdata = d; grf_pc = pc;
    endtask

    task automatic set_dm(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
        dm_we = 1; dm_addr = a; dm_wdata = d; dm_pc = pc;
    endtask

    task automatic test_reset();
        reset = 0;
        out_ready = 0;
        clear_ev();
        set_grf(5'd3, 32'h55, 32'h10);
        set_dm(32'h20, 32'h66, 32'h14);
        step();
        step();
        reset = 1;
        clear_ev();
        n_total++;
        if (obs !== 98'd0) $display("FAIL reset_payload: got %h expected 0", obs);
        else n_pass++;
        n_total++;
        if ({overflow, drop_count} !== 17'd0)
            $display("FAIL reset_drop: got ovf=%0b cnt=%0d expected 0/0", overflow, drop_count);
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_discard: got valid=%0b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_single_grf();
        set_grf(5'd5, 32'h1234, 32'h3000);
        out_ready = 1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL single_no_comb: got valid=%0b expected 0", out_valid);
        else n_pass++;
        step();
        clear_ev();
        n_total++;
        if (obs !== {1'b1, 1'b0, 32'h3000, 32'd5, 32'h1234})
            $display("FAIL single_head: got %h expected %h", obs,
                     {1'b1, 1'b0, 32'h3000, 32'd5, 32'h1234});
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL single_popped: got valid=%0b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_zero_filter();
        set_grf(5'd0, 32'hDEAD, 32'h3004);
        step();
        clear_ev();
        n_total++;
        if ({out_valid, overflow, drop_count} !== 18'd0)
            $display("FAIL zero_filter: got valid=%0b ovf=%0b cnt=%0d expected 0/0/0",
                     out_valid, overflow, drop_count);
        else n_pass++;
    endtask

    task automatic test_dual();
        out_ready = 1;
        set_grf(5'd8, 32'hA, 32'h100);
        set_dm(32'h10, 32'hB, 32'h104);
        step();
        clear_ev();
        n_total++;
        if (obs !== {1'b1, 1'b0, 32'h100, 32'd8, 32'hA})
            $display("FAIL dual_grf_first: got %h expected %h", obs,
                     {1'b1, 1'b0, 32'h100, 32'd8, 32'hA});
        else n_pass++;
        step();
        n_total++;
        if (obs !== {1'b1, 1'b1, 32'h104, 32'h10, 32'hB})
            $display("FAIL dual_dm_second: got %h expected %h", obs,
                     {1'b1, 1'b1, 32'h104, 32'h10, 32'hB});
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL dual_empty: got valid=%0b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_overflow_fill();
        logic [97:0] exp_q[$];
        out_ready = 0;
        for (int i = 0; i < 7; i++) begin
            set_grf(5'(i + 1), 32'h100 + i, 32'h1000 + 4 * i);
            exp_q.push_back({1'b1, 1'b0, 32'h1000 + 4 * i, 32'(i + 1), 32'h100 + i});
            step();
        end
        // free = 1: GRF fits, DM is dropped
        set_grf(5'd20, 32'h200, 32'h2000);
        set_dm(32'h40, 32'h300, 32'h2004);
        exp_q.push_back({1'b1, 1'b0, 32'h2000, 32'd20, 32'h200});
        step();
        clear_ev();
        n_total++;
        if ({overflow, drop_count} !== {1'b1, 16'd1})
            $display("FAIL fill_drop: got ovf=%0b cnt=%0d expected 1/1", overflow, drop_count);
        else n_pass++;
        step();
        n_total++;
        if (obs !== exp_q[0]) $display("FAIL fill_hold: got %h expected %h", obs, exp_q[0]);
        else n_pass++;
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (obs !== exp_q[i])
                $display("FAIL fill_drain_%0d: got %h expected %h", i, obs, exp_q[i]);
            else n_pass++;
            step();
        end
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL fill_empty: got valid=%0b expected 0", out_valid);
        else n_pass++;
        out_ready = 0;
    endtask

    task automatic test_full_push_pop();
        logic [97:0] exp_q[$];
        out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            set_grf(5'(i + 1), 32'h500 + i, 32'h5000 + 4 * i);
            exp_q.push_back({1'b1, 1'b0, 32'h5000 + 4 * i, 32'(i + 1), 32'h500 + i});
            step();
        end
        // Full: the pop happens, the new GRF event is dropped
        set_grf(5'd9, 32'h999, 32'h5100);
        out_ready = 1;
        step();
        clear_ev();
        n_total++;
        if ({overflow, drop_count} !== {1'b1, 16'd2})
            $display("FAIL full_pp_drop: got ovf=%0b cnt=%0d expected 1/2", overflow, drop_count);
        else n_pass++;
        for (int i = 1; i < 8; i++) begin
            n_total++;
            if (obs !== exp_q[i])
                $display("FAIL full_pp_drain_%0d: got %h expected %h", i, obs, exp_q[i]);
            else n_pass++;
            step();
        end
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL full_pp_empty: got valid=%0b expected 0", out_valid);
        else n_pass++;
        out_ready = 0;
    endtask

    task automatic test_reset_flush();
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            set_grf(5'(i + 1), 32'h700 + i, 32'h7000 + 4 * i);
            step();
        end
        clear_ev();
        reset = 0;
        step();
        reset = 1;
        n_total++;
        if ({obs, overflow, drop_count} !== 115'd0)
            $display("FAIL flush_state: got obs=%h ovf=%0b cnt=%0d expected all 0",
                     obs, overflow, drop_count);
        else n_pass++;
        set_dm(32'h80, 32'hCAFE, 32'h6000);
        out_ready = 1;
        step();
        clear_ev();
        n_total++;
        if (obs !== {1'b1, 1'b1, 32'h6000, 32'h80, 32'hCAFE})
            $display("FAIL flush_latency: got %h expected %h", obs,
                     {1'b1, 1'b1, 32'h6000, 32'h80, 32'hCAFE});
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL flush_empty: got valid=%0b expected 0", out_valid);
        else n_pass++;
        out_ready = 0;
    endtask

    task automatic test_saturate();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_grf(5'(i + 1), 32'h800 + i, 32'h8000);
            set_dm(32'h100 + 4 * i, 32'h900 + i, 32'h8004);
            step();
        end
        n_total++;
        if ({overflow, drop_count} !== 17'd0)
            $display("FAIL sat_fill_nodrop: got ovf=%0b cnt=%0d expected 0/0", overflow, drop_count);
        else n_pass++;
        for (int i = 0; i < 32767; i++) step();
        n_total++;
        if (drop_count !== 16'hFFFE)
            $display("FAIL sat_pre: got %h expected fffe", drop_count);
        else n_pass++;
        step();
        n_total++;
        if (drop_count !== 16'hFFFF)
            $display("FAIL sat_clip: got %h expected ffff", drop_count);
        else n_pass++;
        clear_ev();
        set_grf(5'd1, 32'h1, 32'h1);
        step();
        clear_ev();
        n_total++;
        if ({overflow, drop_count} !== {1'b1, 16'hFFFF})
            $display("FAIL sat_hold: got ovf=%0b cnt=%h expected 1/ffff", overflow, drop_count);
        else n_pass++;
        n_total++;
        if (obs !== {1'b1, 1'b0, 32'h8000, 32'd1, 32'h800})
            $display("FAIL sat_head: got %h expected %h", obs, {1'b1, 1'b0, 32'h8000, 32'd1, 32'h800});
        else n_pass++;
        reset = 0;
        step();
        reset = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0;
        out_ready = 0;
        clear_ev();
        @(negedge clk);
        test_reset();
        test_single_grf();
        test_zero_filter();
        test_dual();
        test_overflow_fill();
        test_full_push_pop();
        test_reset_flush();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
